// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, pixel word layout and capture states.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} cap_state_t;
endpackage

// File: rtl/vga_captura_if.sv
// Video input stream plus the frame-RAM write port and status of the capture block.
interface vga_captura_if #(parameter int ADDR_W = 18);
  logic              start;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hsync;
  logic              vsync;
  logic              n_blank;
  logic [ADDR_W-1:0] address;
  logic [23:0]       data;
  logic              we;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (output start, red, green, blue, hsync, vsync, n_blank,
                  input  address, data, we, busy, frame_done, frame_err);
  modport slave  (input  start, red, green, blue, hsync, vsync, n_blank,
                  output address, data, we, busy, frame_done, frame_err);
endinterface

// File: rtl/vga_captura_sampler.sv
// Input register stage of the capture path and the sync/blank edge pulses derived from it.
module vga_sync_sampler
  import vga_pkg::*;
(
  input  logic       clock_25,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       vsync,
  input  logic       n_blank,
  output pixel_t     pixel,
  output logic       n_blank_r,
  output logic       vs_fall,
  output logic       nb_rise,
  output logic       nb_fall
);
  logic vsync_r;
  logic vsync_q;
  logic n_blank_q;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      pixel     <= '0;
      vsync_r   <= 1'b0;
      vsync_q   <= 1'b0;
      n_blank_r <= 1'b0;
      n_blank_q <= 1'b0;
    end else begin
      pixel     <= {red, green, blue};
      vsync_r   <= vsync;
      vsync_q   <= vsync_r;
      n_blank_r <= n_blank;
      n_blank_q <= n_blank_r;
    end
  end

  assign vs_fall = vsync_q & ~vsync_r;
  assign nb_rise = n_blank_r & ~n_blank_q;
  assign nb_fall = n_blank_q & ~n_blank_r;
endmodule

// File: rtl/vga_captura.sv
// Captures one IMG_W x IMG_H window of a requested frame into a frame RAM as {R,G,B} words.
module vga_captura
  import vga_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X0     = 192,
  parameter int Y0     = 112,
  parameter int ADDR_W = 18
) (
  input  logic          clock_25,
  input  logic          reset,
  vga_captura_if.slave  bus
);
  localparam logic [9:0] COL_LO = 10'(X0);
  localparam logic [9:0] COL_HI = 10'(X0 + IMG_W - 1);
  localparam logic [9:0] ROW_LO = 10'(Y0);
  localparam logic [9:0] ROW_HI = 10'(Y0 + IMG_H - 1);

  pixel_t            pixel;
  logic              n_blank_r;
  logic              vs_fall;
  logic              nb_rise;
  logic              nb_fall;
  logic [9:0]        col;
  logic [9:0]        col_cur;
  logic [9:0]        row;
  logic              in_win;
  logic              last_px;
  logic [ADDR_W-1:0] x_off;
  logic [ADDR_W-1:0] y_off;
  logic [ADDR_W-1:0] wr_addr;
  cap_state_t        state;
  logic [ADDR_W-1:0] address;
  logic [23:0]       data;
  logic              we;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  vga_sync_sampler u_sampler (
    .clock_25  (clock_25),
    .reset     (reset),
    .red       (bus.red),
    .green     (bus.green),
    .blue      (bus.blue),
    .vsync     (bus.vsync),
    .n_blank   (bus.n_blank),
    .pixel     (pixel),
    .n_blank_r (n_blank_r),
    .vs_fall   (vs_fall),
    .nb_rise   (nb_rise),
    .nb_fall   (nb_fall)
  );

  // col holds the index of the next active pixel; the clear on nb_rise is applied
  // combinationally so the first pixel of a line is column 0 in its own cycle.
  assign col_cur = nb_rise ? 10'd0 : col;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      if (n_blank_r)
        col <= (col_cur == 10'h3FF) ? col_cur : col_cur + 10'd1;
      if (vs_fall)
        row <= '0;
      else if (nb_fall && row != 10'h3FF)
        row <= row + 10'd1;
    end
  end

  assign in_win  = n_blank_r && (col_cur >= COL_LO) && (col_cur <= COL_HI)
                   && (row >= ROW_LO) && (row <= ROW_HI);
  assign last_px = in_win && (col_cur == COL_HI) && (row == ROW_HI);
  assign x_off   = ADDR_W'(col_cur - COL_LO);
  assign y_off   = ADDR_W'(row - ROW_LO);
  assign wr_addr = y_off * ADDR_W'(IMG_W) + x_off;

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      data       <= '0;
      we         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= bus.start;
          if (bus.start)
            state <= ARMED;
        end
        ARMED: begin
          busy <= 1'b1;
          if (vs_fall)
            state <= CAPTURE;
        end
        CAPTURE: begin
          // busy stays high through the frame_done cycle and drops one cycle later
          busy <= 1'b1;
          if (vs_fall) begin
            frame_err <= 1'b1;
          end else if (in_win) begin
            we      <= 1'b1;
            address <= wr_addr;
            data    <= pixel;
            if (last_px) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address    = address;
  assign bus.data       = data;
  assign bus.we         = we;
  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.frame_err  = frame_err;
endmodule

// File: doc/vga_captura.md
# vga_captura

Receiving end of the VGA pixel stream that `controlador_vga` produces. Runs in the 25 MHz pixel domain and samples `red/green/blue`, `hsync`, `vsync` and `n_blank`. On request it captures one rectangular window of one frame into a frame RAM as 24-bit `{R,G,B}` words through a simple write port (`address`/`data`/`we`). It is used to loop the display back into memory, so the processor can read rendered frames and the bench can check them.

## Interface
- `IMG_W`, 256: window width in pixels
- `IMG_H`, 256: window height in lines
- `X0`, 192: first captured column, counted among active pixels of a line
- `Y0`, 112: first captured line, counted among active lines of a frame
- `ADDR_W`, 18: RAM address width; requires `IMG_W*IMG_H <= 2**ADDR_W`

- `clock_25`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; arms capture of the next full frame
- `red`, `green`, `blue`  in  8 each  pixel colour
- `hsync`, `vsync`  in  1  active-low syncs
- `n_blank`  in  1  high during active video
- `address`  out  ADDR_W  RAM write address
- `data`  out  24  `{red,green,blue}`
- `we`  out  1  write strobe, one cycle per pixel
- `busy`  out  1  high while ARMED or CAPTURE
- `frame_done`  out  1  one-cycle pulse when the window is complete
- `frame_err`  out  1  one-cycle pulse when a frame is truncated

## Operation
- **Input registering.** Every input is registered once.
- **Edge detection** on the registered signals:
  - `vs_fall`: `vsync` goes 1→0. This marks frame start.
  - `nb_rise` / `nb_fall`: `n_blank` goes 0→1 / 1→0.
- **Counters.**
  - `col` is cleared on `nb_rise` and increments on every cycle where the registered `n_blank` is 1.
  - `row` is cleared on `vs_fall` and increments on every `nb_fall`.
  - Both are 10 bits wide and saturate at 1023.
- **Window test.** `in_win = n_blank_r && col∈[X0, X0+IMG_W) && row∈[Y0, Y0+IMG_H)`.
- **State machine** (`IDLE`, `ARMED`, `CAPTURE`):
  - `IDLE`: `start` moves to `ARMED`.
  - `ARMED`: `vs_fall` moves to `CAPTURE`.
  - `CAPTURE`: on each `in_win` cycle, write pixel `(col-X0, row-Y0)` to `address = (row-Y0)*IMG_W + (col-X0)`. The address arithmetic is unsigned at `ADDR_W` bits.
  - `CAPTURE`, last pixel: writing `(IMG_W-1, IMG_H-1)` pulses `frame_done` and moves to `IDLE`.
  - `CAPTURE`, truncated frame: if `vs_fall` arrives before the window is complete, pulse `frame_err` and stay in `CAPTURE`. Counters restart and capture continues on the new frame; earlier RAM contents are overwritten.
- **`start` outside `IDLE`** (in `ARMED` or `CAPTURE`) is ignored.
- **`start` and `vs_fall` in the same cycle in `IDLE`**: go to `ARMED` only. That `vs_fall` does not count, so capture waits for the following frame.
- **Outside the window**, or in `IDLE`/`ARMED`: `we`=0. `address` and `data` hold their last values.

## Timing
- **Reset values:** `address`=0, `data`=0, `we`=0, `busy`=0, `frame_done`=0, `frame_err`=0, state `IDLE`, `col`=0, `row`=0.
- **Write latency.** A pixel presented at cycle n appears as registered `address`/`data`/`we` at cycle n+2: one cycle for the input register, one for the output register.
- **`frame_done`** is asserted in the same cycle as the final `we`.
- **`frame_err`** is asserted 2 cycles after the `vsync` falling edge at the pins.
- **`busy`** rises 1 cycle after `start` and falls in the cycle after `frame_done`.
- **Reset mid-capture.** Reset takes effect at the next edge. No further `we` and no `frame_done` are issued.
- **Throughput.** One pixel per clock. There is no backpressure: the RAM must accept a write every cycle.

## Structure
- **Package `vga_pkg`** holds:
  - the 640×480@60 timing constants (`H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, `V_*`);
  - typedef `pixel_t` (24-bit `{r,g,b}`);
  - enum `cap_state_t`.
  
  `controlador_vga` reuses the timing constants.
- **Sub-module `vga_sync_sampler`** holds the input register stage and the `vs_fall`/`nb_rise`/`nb_fall` edge pulses.
- **Top** holds the counters, the state machine and the output register.

## Test plan
- **Full window.** Drive a full 640×480 frame from `controlador_vga` timing, with `{R,G,B} = {col[7:0], row[7:0], 8'h5A}`, and pulse `start`. Expect:
  - exactly 65536 `we` pulses;
  - `address` 0 carries `{8'd192, 8'd112, 8'h5A}`;
  - `address` 65535 carries `{8'd191, 8'd111, 8'h5A}` (col 447 and row 367, truncated to 8 bits);
  - a `frame_done` pulse coincident with the last write.
- **No start.** Run two frames without `start`. Expect zero `we`, `busy`=0 and no pulses.
- **Start coincident with `vs_fall`.** Expect the first `we` to land in the second frame, not the first.
- **Truncated frame.** Drive `vsync` low after line 200. Expect:
  - a `frame_err` pulse;
  - writes resuming at `address` 0 in the next frame;
  - exactly one `frame_done` at the end of that frame.
- **Reset mid-capture.** Assert `reset` at line 150 of capture. Expect all outputs to equal their reset values one edge later, and no `we` afterwards until the next `start` and the following frame.
- **Start while busy.** Pulse `start` while in `CAPTURE`. Expect no effect: one `frame_done` and 65536 writes in total.
